// File: rtl/pipe_pkg.sv
// Shared constants, the stage slot type and the pipeline geometry check
// used by stall_pipe_ctrl and its stage registers.
package pipe_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_STAGES    = 5;
    localparam int DEF_MEM_STAGE = 3;

    typedef struct packed {
        logic                  valid;
        logic [DEF_DATA_W-1:0] data;
    } stage_t;

    // The memory stage needs a feeder stage and at least one stage behind it.
    function automatic bit geometry_ok(int stages, int mem_stage);
        return (stages >= 3) && (stages <= 16) &&
               (mem_stage >= 1) && (mem_stage <= stages - 2);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline slot: valid bit plus payload. Load wins over clear; with
// neither asserted the slot holds.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/stall_pipe_ctrl.sv
// In-order pipeline with per-stage valid bits, a combinational ready chain,
// one memory stage waiting on a req/done handshake, and saturating counters.
module stall_pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STAGES    = DEF_STAGES,
    parameter int MEM_STAGE = DEF_MEM_STAGE,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int M = MEM_STAGE;
    localparam int L = STAGES - 1;

    if (!geometry_ok(STAGES, MEM_STAGE)) begin : g_bad_geometry
        $error("stall_pipe_ctrl: STAGES must be 3..16 and MEM_STAGE 1..STAGES-2");
    end

    logic [STAGES-1:0] v, leave, ready, xfer, load, clear;
    logic [DATA_W-1:0] d         [STAGES];
    logic [DATA_W-1:0] load_data [STAGES];
    logic              m_done_q, m_done_d;
    logic              mem_fire, mem_capture;
    logic [CNT_W-1:0]  stall_q, stall_d, bubble_q, bubble_d;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_stage_reg #(.DATA_W(DATA_W)) u_reg (
            .clk_i   (clk),
            .rst_ni  (reset),
            .load_i  (load[g]),
            .clear_i (clear[g]),
            .data_i  (load_data[g]),
            .valid_o (v[g]),
            .data_o  (d[g])
        );
    end

    assign mem_req     = v[M] & ~m_done_q;
    assign mem_fire    = mem_req & mem_done;
    assign mem_capture = mem_fire & ~xfer[M];

    // Ready is built tail-to-head in a local so the chain stays purely combinational.
    always_comb begin
        logic r;
        leave    = '1;
        leave[M] = m_done_q | mem_fire;
        r        = ~v[L] | out_ready;
        ready[L] = r;
        for (int i = L - 1; i >= 0; i--) begin
            r        = ~v[i] | (leave[i] & r);
            ready[i] = r;
        end
    end

    always_comb begin
        xfer = '0;
        for (int i = 0; i < L; i++) begin
            xfer[i] = v[i] & leave[i] & ready[i+1];
        end
        xfer[L] = v[L] & out_ready;
    end

    assign in_ready = ready[0] & ~flush;

    // Flush empties the stages in front of the memory stage and kills anything moving into it.
    always_comb begin
        load         = '0;
        clear        = '0;
        load_data[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            load_data[i] = d[i-1];
        end
        load[0] = in_valid & in_ready;
        for (int i = 1; i < STAGES; i++) begin
            load[i] = xfer[i-1] && !(flush && (i <= M));
        end
        for (int i = 0; i < STAGES; i++) begin
            clear[i] = xfer[i] || (flush && (i < M));
        end
        load_data[M]   = mem_capture ? mem_rdata : d[M-1];
        load_data[M+1] = m_done_q ? d[M] : mem_rdata;
        load[M]        = load[M] | mem_capture;
    end

    always_comb begin
        m_done_d = m_done_q;
        if (xfer[M]) begin
            m_done_d = 1'b0;
        end
        if (mem_capture) begin
            m_done_d = 1'b1;
        end else if (load[M]) begin
            m_done_d = 1'b0;
        end
    end

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (v[M] && !leave[M] && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (out_ready && !v[L] && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_done_q <= 1'b0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            m_done_q <= m_done_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign mem_addr   = d[M];
    assign out_valid  = v[L];
    assign out_data   = d[L];
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_stall_pipe_ctrl.sv
// Self-checking bench for stall_pipe_ctrl: directed scenarios plus a random
// stream scored against an in-order queue and a delay-driven dmem model.
module tb_stall_pipe_ctrl;

    localparam int DATA_W    = 32;
    localparam int STAGES    = 5;
    localparam int MEM_STAGE = 3;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_done = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    always #5 clk = ~clk;

    stall_pipe_ctrl #(
        .DATA_W    (DATA_W),
        .STAGES    (STAGES),
        .MEM_STAGE (MEM_STAGE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_v;
    int                delay_q[$];
    bit                auto_push = 1'b1;
    bit                dmem_manual = 1'b0;
    logic              manual_done = 1'b0;
    logic [DATA_W-1:0] manual_rdata = '0;
    int                max_delay = 0;
    int                cur_delay = 0;
    int                wait_cnt = 0;
    bit                cur_valid = 1'b0;
    int                stall_exp = 0;
    bit                accepted = 1'b0;
    bit                fired = 1'b0;
    bit                req_seen = 1'b0;
    int                n_out = 0;

    function automatic int sat(input int x);
        return (x > CNT_MAX) ? CNT_MAX : x;
    endfunction

    // Negedge half of a cycle: dmem responds, then outputs are sampled and scored.
    task automatic cyc_sample();
        @(negedge clk);
        fired    = 1'b0;
        req_seen = mem_req;
        if (dmem_manual) begin
            mem_done  = manual_done;
            mem_rdata = manual_rdata;
        end else begin
            mem_done  = 1'b0;
            mem_rdata = '0;
            if (mem_req) begin
                if (!cur_valid) begin
                    if (delay_q.size() > 0) cur_delay = delay_q.pop_front();
                    else cur_delay = $urandom_range(0, max_delay);
                    cur_valid = 1'b1;
                    wait_cnt  = 0;
                end
                if (wait_cnt >= cur_delay) begin
                    mem_done  = 1'b1;
                    mem_rdata = mem_addr + 32'h100;
                    fired     = 1'b1;
                    stall_exp += cur_delay;
                end
            end
        end
        #1;
        accepted = in_valid && in_ready;
        if (accepted && auto_push) exp_q.push_back(in_data + 32'h100);
        if (out_valid && out_ready) begin
            n_out++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_order: got unexpected output %h, required none", out_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (out_data !== exp_v) begin
                    n_fail++;
                    $display("FAIL out_data: got %h required %h", out_data, exp_v);
                end
            end
        end
    endtask

    task automatic cyc_commit();
        @(posedge clk);
        #1;
        if (fired) cur_valid = 1'b0;
        else if (req_seen && !dmem_manual) wait_cnt++;
    endtask

    task automatic tick();
        cyc_sample();
        cyc_commit();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        mem_done = 1'b0; mem_rdata = '0;
        dmem_manual = 1'b0; manual_done = 1'b0; manual_rdata = '0;
        cur_valid = 1'b0; wait_cnt = 0; stall_exp = 0; max_delay = 0;
        auto_push = 1'b1; n_out = 0;
        exp_q.delete();
        delay_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt); end
        n_checks++; if (bubble_cnt !== '0) begin n_fail++; $display("FAIL reset_bubble_cnt: got %0d required 0", bubble_cnt); end
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] data;
        int exp_bub;
        do_reset();
        out_ready = 1'b1;
        data = 1;
        exp_bub = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (data <= 10);
            in_data  = data;
            cyc_sample();
            n_checks++;
            if (out_valid !== ((c >= STAGES) && (c < STAGES + 10))) begin
                n_fail++;
                $display("FAIL stream_out_valid c=%0d: got %b required %b", c, out_valid, (c >= STAGES) && (c < STAGES + 10));
            end
            if (c < 10) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d: got %b required 1", c, in_ready); end
            end
            if (!((c >= STAGES) && (c < STAGES + 10))) exp_bub++;
            cyc_commit();
            if (accepted) data++;
        end
        in_valid = 1'b0;
        n_checks++; if (n_out != 10) begin n_fail++; $display("FAIL stream_count: got %0d required 10", n_out); end
        n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL stream_stall_cnt: got %0d required 0", stall_cnt); end
        n_checks++; if (bubble_cnt !== CNT_W'(sat(exp_bub))) begin n_fail++; $display("FAIL stream_bubble_cnt: got %0d required %0d", bubble_cnt, sat(exp_bub)); end
    endtask

    task automatic test_mem_wait();
        int sent, held, low;
        do_reset();
        out_ready = 1'b1;
        delay_q.push_back(4);
        sent = 0; held = 0; low = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (sent < 8);
            in_data  = (sent == 0) ? 32'hA5 : 32'hB0 + sent;
            cyc_sample();
            if (mem_req && !mem_done && mem_addr == 32'hA5) held++;
            if (in_valid && !in_ready) low++;
            cyc_commit();
            if (accepted) sent++;
        end
        in_valid = 1'b0;
        n_checks++; if (held != 4) begin n_fail++; $display("FAIL wait_mem_req_held: got %0d required 4", held); end
        n_checks++; if (low != 4) begin n_fail++; $display("FAIL wait_in_ready_low: got %0d required 4", low); end
        n_checks++; if (stall_cnt !== CNT_W'(sat(stall_exp))) begin n_fail++; $display("FAIL wait_stall_cnt: got %0d required %0d", stall_cnt, sat(stall_exp)); end
        n_checks++; if (n_out != 8 || exp_q.size() != 0) begin n_fail++; $display("FAIL wait_count: got %0d out %0d pending required 8 out 0 pending", n_out, exp_q.size()); end
    endtask

    task automatic test_early_done();
        logic [DATA_W-1:0] data;
        do_reset();
        out_ready = 1'b0;
        data = 32'h20;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            in_data  = data;
            tick();
            if (accepted) data++;
        end
        cyc_sample();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL early_full_in_ready: got %b required 0", in_ready); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL early_mem_req: got %b required 0", mem_req); end
        n_checks++; if (mem_addr !== 32'h121) begin n_fail++; $display("FAIL early_capture: got %h required 121", mem_addr); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h120) begin n_fail++; $display("FAIL early_head: got %b/%h required 1/120", out_valid, out_data); end
        cyc_commit();
        in_valid = 1'b0;
        dmem_manual = 1'b1; manual_done = 1'b1; manual_rdata = 32'hDEAD;
        tick();
        manual_done = 1'b0;
        cyc_sample();
        n_checks++; if (mem_addr !== 32'h121) begin n_fail++; $display("FAIL early_second_done: got %h required 121", mem_addr); end
        cyc_commit();
        dmem_manual = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) tick();
        n_checks++; if (n_out != 5 || exp_q.size() != 0) begin n_fail++; $display("FAIL early_drain: got %0d out %0d pending required 5 out 0 pending", n_out, exp_q.size()); end
        n_checks++; if (stall_cnt !== CNT_W'(sat(stall_exp))) begin n_fail++; $display("FAIL early_stall_cnt: got %0d required %0d", stall_cnt, sat(stall_exp)); end
    endtask

    task automatic test_flush();
        int late_req;
        do_reset();
        auto_push = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(32'h131);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c != 1);
            in_data  = 32'h31 + c;
            tick();
        end
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h40;
        cyc_sample();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b required 0", in_ready); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h131) begin n_fail++; $display("FAIL flush_downstream: got %b/%h required 1/131", out_valid, out_data); end
        cyc_commit();
        flush = 1'b0;
        in_valid = 1'b0;
        late_req = 0;
        for (int c = 0; c < 10; c++) begin
            cyc_sample();
            if (mem_req) late_req++;
            cyc_commit();
        end
        n_checks++; if (late_req != 0) begin n_fail++; $display("FAIL flush_mem_empty: got %0d req cycles required 0", late_req); end
        n_checks++; if (n_out != 1 || exp_q.size() != 0) begin n_fail++; $display("FAIL flush_count: got %0d out required 1", n_out); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 6) begin
                n_checks++; if (bubble_cnt !== CNT_W'(7)) begin n_fail++; $display("FAIL sat_bubble_mid: got %0d required 7", bubble_cnt); end
            end
        end
        n_checks++; if (bubble_cnt !== CNT_W'(CNT_MAX)) begin n_fail++; $display("FAIL sat_bubble_end: got %0d required %0d", bubble_cnt, CNT_MAX); end
    endtask

    task automatic test_async_reset();
        int bad;
        do_reset();
        auto_push = 1'b0;
        dmem_manual = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c == 0);
            in_data  = 32'h40;
            tick();
        end
        in_valid = 1'b0;
        cyc_sample();
        n_checks++; if (mem_req !== 1'b1 || stall_cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL areset_pre: got req %b stall %0d required 1/2", mem_req, stall_cnt); end
        reset = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL areset_mem_req: got %b required 0", mem_req); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b required 0", out_valid); end
        n_checks++; if (stall_cnt !== '0 || bubble_cnt !== '0) begin n_fail++; $display("FAIL areset_counters: got %0d/%0d required 0/0", stall_cnt, bubble_cnt); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            cyc_sample();
            if (mem_req || out_valid) bad++;
            cyc_commit();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL areset_late_done: got %0d active cycles required 0", bad); end
        n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL areset_stall_after: got %0d required 0", stall_cnt); end
    endtask

    task automatic test_random();
        bit pend;
        int total;
        do_reset();
        max_delay = 2;
        pend = 1'b0;
        total = 0;
        for (int c = 0; c < 200; c++) begin
            if (!pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (accepted) total++;
            pend = in_valid && !accepted;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick();
        n_checks++; if (exp_q.size() != 0 || n_out != total) begin n_fail++; $display("FAIL random_drain: got %0d out of %0d, %0d pending, required all", n_out, total, exp_q.size()); end
        n_checks++; if (stall_cnt !== CNT_W'(sat(stall_exp))) begin n_fail++; $display("FAIL random_stall_cnt: got %0d required %0d", stall_cnt, sat(stall_exp)); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_mem_wait();
        test_early_done();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stall_pipe_ctrl.md
Name: stall_pipe_ctrl

Overview:
Parametrised in-order pipeline with per-stage valid bits, a backpressure chain and one memory stage that waits on a req/done handshake. It replaces fixed id/ex/mem/wb registers that all freeze together: an entry stalls only the stages that are actually blocked, and bubbles collapse. It sits between the instruction-fetch front end (stalling imem) and writeback. The memory stage talks to the stalling dmem. Saturating stall and bubble counters are provided for performance analysis.

Parameters:
DATA_W, 32, width of each stage payload
STAGES, 5, number of pipeline stages (legal range 3..16)
MEM_STAGE, 3, index of the memory-wait stage (legal range 1..STAGES-2)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  front end presents an entry (imem done)
in_data  in  DATA_W  entry payload
in_ready  out  1  stage 0 accepts this cycle
flush  in  1  kill all entries in stages 0..MEM_STAGE-1
mem_req  out  1  memory stage requests an access
mem_addr  out  DATA_W  payload of the memory-stage entry
mem_done  in  1  single-cycle completion pulse from dmem
mem_rdata  in  DATA_W  read data, valid with mem_done
out_valid  out  1  last stage holds an entry
out_data  out  DATA_W  last-stage payload
out_ready  in  1  writeback consumes
stall_cnt  out  CNT_W  cycles the memory stage waited
bubble_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0

Behaviour:
- Reset (reset=0, async): all v[i]=0, m_done=0, data regs=0, counters=0. Therefore in_ready=1 combinationally, mem_req=0, out_valid=0, out_data=0.
- Reset asserted mid-access drops mem_req immediately. dmem must tolerate an abandoned request. A mem_done arriving during or after reset with mem_req=0 is ignored.
- Per-stage state: v[i], d[i]. Stage MEM_STAGE also has an m_done flag.
- leave[i] = 1 for i≠MEM_STAGE. leave[MEM_STAGE] = m_done | mem_done.
- ready[STAGES-1] = ~v[STAGES-1] | out_ready.
- ready[i] = ~v[i] | (leave[i] & ready[i+1]). The chain is combinational, with no registered skid.
- in_ready = ready[0] & ~flush.
- Transfer i→i+1 when v[i] & leave[i] & ready[i+1]. Receiving stage latches the data and sets v.
- A sending stage that receives nothing clears its v.
- Accept when in_valid & in_ready. Handshake loss: none. in_data must stay stable while in_valid=1 and in_ready=0.
- Memory stage:
  - mem_req = v[M] & ~m_done.
  - mem_addr = d[M].
  - mem_done while mem_req=1: if the entry also leaves this cycle, it carries mem_rdata forward (zero-latency pass). Otherwise d[M]←mem_rdata and m_done←1.
  - mem_done while mem_req=0: ignored.
  - m_done clears when the entry leaves.
  - A new entry entering M always starts with m_done=0.
- Last stage: out_valid=v[STAGES-1], out_data=d[STAGES-1]. An entry leaves on out_ready.
- Flush (synchronous): v[0..MEM_STAGE-1]←0 and no input is accepted that cycle.
  - If flush coincides with a transfer MEM_STAGE-1→MEM_STAGE, the transfer is killed and M becomes empty (or keeps its own entry if it did not leave).
  - Stages ≥ MEM_STAGE are unaffected. An in-flight memory access completes normally.
- Counters increment by 1 and saturate at all-ones; they never wrap.
  - stall_cnt increments when v[M] & ~leave[M].
  - bubble_cnt increments when out_ready & ~out_valid.
- Ordering: entries exit in acceptance order. Throughput is 1/cycle when mem_done returns in the same cycle as mem_req and out_ready=1.
- Latency: accept to out_valid is STAGES cycles with no stalls.

Decomposition:
- Package pipe_pkg holds: the STAGES/MEM_STAGE legality checks (elaboration-time assertion), the default DATA_W/CNT_W constants, and a stage_t typedef {valid, data}.
- One sub-module, pipe_stage_reg: a single valid+data slot with load/clear/hold controls and an async active-low reset. It is instantiated STAGES times via generate.
- Ready-chain, memory-stage and counter logic live in the top module.

Test Plan:
- Reset/stream: release reset, in_valid=1 with data 1..10 each cycle, mem_done tied to mem_req, mem_rdata=mem_addr+0x100, out_ready=1 -> out_valid first at cycle 5 after the first accept; out_data 0x101..0x10A in order, back-to-back; stall_cnt=0.
- Memory wait: entry 0xA5 reaches M, mem_done withheld 4 cycles -> mem_req held for 4 cycles, stages 0..M-1 fill then in_ready=0, stages after M drain, stall_cnt=4, no entry lost or duplicated.
- Early done/late leave: out_ready=0 with the pipe full, then a mem_done pulse -> m_done set, mem_req drops the next cycle; a second mem_done pulse is ignored; data captured once.
- Flush during transfer: flush in the same cycle as M-1→M with M empty -> M empty next cycle, stages <M empty, in_ready=0 that cycle, downstream entries exit unchanged.
- Saturation: CNT_W=4, out_ready=1 with no input for 20 cycles -> bubble_cnt sticks at 15.
- Async reset mid-access: assert reset while mem_req=1 -> mem_req, out_valid and counters go to 0 before the next clk edge; a late mem_done after release is ignored.
